// File: rtl/axi4_lite_pkg.sv
// Shared response codes, FSM state enums and address helpers for the AXI4-Lite slave.
package axi4_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_WAIT_W,
        WR_WAIT_AW,
        WR_RESP
    } wr_state_t;

    typedef enum logic {
        RD_IDLE,
        RD_RESP
    } rd_state_t;

    function automatic logic addr_in_range(input logic [31:0] addr, input int idx_w);
        return (addr >> (idx_w + 2)) == 32'd0;
    endfunction

endpackage

// File: rtl/axi4_lite_regfile.sv
// Byte-strobed 32-bit register array: one write port, one combinational read port.
module axi4_lite_regfile
    import axi4_lite_pkg::*;
#(
    parameter int NUM_REGS = 16,
    localparam int IDX_W = $clog2(NUM_REGS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   we,
    input  logic [IDX_W-1:0]       widx,
    input  logic [31:0]            wdata,
    input  logic [3:0]             wstrb,
    input  logic [IDX_W-1:0]       ridx,
    output logic [31:0]            rdata,
    output logic [NUM_REGS*32-1:0] q
);

    logic [31:0] regs [NUM_REGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) regs[widx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    assign rdata = regs[ridx];

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_flat
        assign q[32*i +: 32] = regs[i];
    end

endmodule

// File: rtl/axi4_lite_slave.sv
// AXI4-Lite register slave with independent read/write FSMs.
// Define AXIL_SLV_ADDR_CHECK_EN to answer out-of-range addresses with SLVERR.
module axi4_lite_slave
    import axi4_lite_pkg::*;
#(
    parameter int NUM_REGS = 16,
    localparam int IDX_W = $clog2(NUM_REGS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [31:0]            S_AXI_AWADDR,
    input  logic                   S_AXI_AWVALID,
    output logic                   S_AXI_AWREADY,
    input  logic [31:0]            S_AXI_WDATA,
    input  logic [3:0]             S_AXI_WSTRB,
    input  logic                   S_AXI_WVALID,
    output logic                   S_AXI_WREADY,
    output logic [1:0]             S_AXI_BRESP,
    output logic                   S_AXI_BVALID,
    input  logic                   S_AXI_BREADY,
    input  logic [31:0]            S_AXI_ARADDR,
    input  logic                   S_AXI_ARVALID,
    output logic                   S_AXI_ARREADY,
    output logic [31:0]            S_AXI_RDATA,
    output logic [1:0]             S_AXI_RRESP,
    output logic                   S_AXI_RVALID,
    input  logic                   S_AXI_RREADY,
    output logic [NUM_REGS*32-1:0] Reg_Q,
    output logic                   Wr_Pulse,
    output logic [IDX_W-1:0]       Wr_Idx
);

    wr_state_t   wr_state;
    rd_state_t   rd_state;
    logic        aw_rdy_q, w_rdy_q, ar_rdy_q;
    logic [31:0] aw_addr_q, w_data_q;
    logic [3:0]  w_strb_q;
    logic        aw_hs, w_hs, ar_hs;
    logic        wr_fire, wr_ok, rd_ok;
    logic [31:0] wr_addr, wr_data, reg_rdata;
    logic [3:0]  wr_strb;
    logic        unused_addr;

    // Ready flags hold the idle value through reset and are masked while rst is high.
    assign S_AXI_AWREADY = aw_rdy_q & ~rst;
    assign S_AXI_WREADY  = w_rdy_q & ~rst;
    assign S_AXI_ARREADY = ar_rdy_q & ~rst;

    assign aw_hs = S_AXI_AWVALID & S_AXI_AWREADY;
    assign w_hs  = S_AXI_WVALID & S_AXI_WREADY;
    assign ar_hs = S_AXI_ARVALID & S_AXI_ARREADY;

    always_comb begin
        wr_fire = 1'b0;
        wr_addr = aw_addr_q;
        wr_data = w_data_q;
        wr_strb = w_strb_q;
        case (wr_state)
            WR_IDLE: begin
                wr_fire = aw_hs & w_hs;
                wr_addr = S_AXI_AWADDR;
                wr_data = S_AXI_WDATA;
                wr_strb = S_AXI_WSTRB;
            end
            WR_WAIT_W: begin
                wr_fire = w_hs;
                wr_data = S_AXI_WDATA;
                wr_strb = S_AXI_WSTRB;
            end
            WR_WAIT_AW: begin
                wr_fire = aw_hs;
                wr_addr = S_AXI_AWADDR;
            end
            default: ;
        endcase
    end

`ifdef AXIL_SLV_ADDR_CHECK_EN
    assign wr_ok = addr_in_range(wr_addr, IDX_W);
    assign rd_ok = addr_in_range(S_AXI_ARADDR, IDX_W);
`else
    assign wr_ok = 1'b1;
    assign rd_ok = 1'b1;
`endif

    assign unused_addr = ^{wr_addr, S_AXI_ARADDR};

    axi4_lite_regfile #(.NUM_REGS(NUM_REGS)) u_regfile (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_fire & wr_ok),
        .widx  (wr_addr[IDX_W+1:2]),
        .wdata (wr_data),
        .wstrb (wr_strb),
        .ridx  (S_AXI_ARADDR[IDX_W+1:2]),
        .rdata (reg_rdata),
        .q     (Reg_Q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state     <= WR_IDLE;
            aw_rdy_q     <= 1'b1;
            w_rdy_q      <= 1'b1;
            S_AXI_BVALID <= 1'b0;
            S_AXI_BRESP  <= RESP_OKAY;
            Wr_Pulse     <= 1'b0;
            Wr_Idx       <= '0;
            aw_addr_q    <= '0;
            w_data_q     <= '0;
            w_strb_q     <= '0;
        end else begin
            Wr_Pulse <= wr_fire & wr_ok;
            if (wr_fire & wr_ok) Wr_Idx <= wr_addr[IDX_W+1:2];
            if (wr_fire) begin
                wr_state     <= WR_RESP;
                aw_rdy_q     <= 1'b0;
                w_rdy_q      <= 1'b0;
                S_AXI_BVALID <= 1'b1;
                S_AXI_BRESP  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
            end else begin
                case (wr_state)
                    WR_IDLE: begin
                        if (aw_hs) begin
                            aw_addr_q <= S_AXI_AWADDR;
                            aw_rdy_q  <= 1'b0;
                            wr_state  <= WR_WAIT_W;
                        end else if (w_hs) begin
                            w_data_q <= S_AXI_WDATA;
                            w_strb_q <= S_AXI_WSTRB;
                            w_rdy_q  <= 1'b0;
                            wr_state <= WR_WAIT_AW;
                        end
                    end
                    WR_RESP: begin
                        if (S_AXI_BREADY) begin
                            S_AXI_BVALID <= 1'b0;
                            aw_rdy_q     <= 1'b1;
                            w_rdy_q      <= 1'b1;
                            wr_state     <= WR_IDLE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state     <= RD_IDLE;
            ar_rdy_q     <= 1'b1;
            S_AXI_RVALID <= 1'b0;
            S_AXI_RRESP  <= RESP_OKAY;
            S_AXI_RDATA  <= '0;
        end else begin
            case (rd_state)
                RD_IDLE: begin
                    if (ar_hs) begin
                        S_AXI_RDATA  <= rd_ok ? reg_rdata : 32'd0;
                        S_AXI_RRESP  <= rd_ok ? RESP_OKAY : RESP_SLVERR;
                        S_AXI_RVALID <= 1'b1;
                        ar_rdy_q     <= 1'b0;
                        rd_state     <= RD_RESP;
                    end
                end
                RD_RESP: begin
                    if (S_AXI_RREADY) begin
                        S_AXI_RVALID <= 1'b0;
                        ar_rdy_q     <= 1'b1;
                        rd_state     <= RD_IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_lite_slave.sv
// Directed self-checking bench for axi4_lite_slave (NUM_REGS=16).
module tb_axi4_lite_slave;

    localparam int NR = 16;
    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   awaddr, wdata, araddr, rdata;
    logic [3:0]    wstrb;
    logic          awvalid, awready, wvalid, wready;
    logic [1:0]    bresp, rresp;
    logic          bvalid, bready, arvalid, arready, rvalid, rready;
    logic [NR*32-1:0] reg_q;
    logic          wr_pulse;
    logic [IW-1:0] wr_idx;

    int checks = 0;
    int errors = 0;

`ifdef AXIL_SLV_ADDR_CHECK_EN
    localparam logic        CHK = 1'b1;
`else
    localparam logic        CHK = 1'b0;
`endif

    always #5 clk = ~clk;

    axi4_lite_slave #(.NUM_REGS(NR)) dut (
        .clk           (clk),
        .rst           (rst),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready),
        .Reg_Q         (reg_q),
        .Wr_Pulse      (wr_pulse),
        .Wr_Idx        (wr_idx)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        awaddr = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0;
        bready = 0; araddr = '0; arvalid = 0; rready = 0;

        // Reset state
        @(negedge clk);
        chk("rst_awready", awready, 0);
        chk("rst_wready", wready, 0);
        chk("rst_arready", arready, 0);
        chk("rst_bvalid", bvalid, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_pulse", wr_pulse, 0);
        chk("rst_regq_zero", (reg_q == '0), 1);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_awready", awready, 1);
        chk("idle_wready", wready, 1);
        chk("idle_arready", arready, 1);

        // AW+W same cycle
        awaddr = 32'h08; awvalid = 1; wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1;
        @(negedge clk);
        awvalid = 0; wvalid = 0;
        chk("t1_bvalid", bvalid, 1);
        chk("t1_bresp", bresp, 2'b00);
        chk("t1_pulse", wr_pulse, 1);
        chk("t1_idx", wr_idx, 2);
        chk("t1_awready", awready, 0);
        chk("t1_reg2", reg_q[95:64], 32'hDEADBEEF);
        bready = 1;
        @(negedge clk);
        bready = 0;
        chk("t1_bvalid_clr", bvalid, 0);
        chk("t1_pulse_clr", wr_pulse, 0);
        araddr = 32'h08; arvalid = 1;
        @(negedge clk);
        arvalid = 0;
        chk("t1_rvalid", rvalid, 1);
        chk("t1_rdata", rdata, 32'hDEADBEEF);
        chk("t1_rresp", rresp, 2'b00);
        chk("t1_arready", arready, 0);
        rready = 1;
        @(negedge clk);
        rready = 0;
        chk("t1_rvalid_clr", rvalid, 0);

        // W three cycles before AW, partial strobe
        wdata = 32'h11223344; wstrb = 4'b0101; wvalid = 1;
        @(negedge clk);
        wvalid = 0;
        chk("t2_wready", wready, 0);
        chk("t2_awready", awready, 1);
        chk("t2_pulse_early", wr_pulse, 0);
        @(negedge clk);
        @(negedge clk);
        awaddr = 32'h04; awvalid = 1;
        @(negedge clk);
        awvalid = 0;
        chk("t2_reg1", reg_q[63:32], 32'h00220044);
        chk("t2_pulse", wr_pulse, 1);
        chk("t2_idx", wr_idx, 1);
        chk("t2_bvalid", bvalid, 1);
        @(negedge clk);
        chk("t2_pulse_one", wr_pulse, 0);

        // BREADY held low; a read runs meanwhile
        for (int i = 0; i < 4; i++) begin
            if (i == 0) begin
                araddr = 32'h04; arvalid = 1;
            end
            @(negedge clk);
            arvalid = 0;
            chk("t3_bvalid", bvalid, 1);
            chk("t3_bresp", bresp, 2'b00);
            chk("t3_awready", awready, 0);
            chk("t3_wready", wready, 0);
            if (i == 0) begin
                chk("t3_rvalid", rvalid, 1);
                chk("t3_rdata", rdata, 32'h00220044);
                rready = 1;
            end else if (i == 1) begin
                chk("t3_rvalid_clr", rvalid, 0);
                rready = 0;
            end
        end
        bready = 1;
        @(negedge clk);
        bready = 0;
        chk("t3_bvalid_clr", bvalid, 0);

        // Out-of-range address 0x40
        awaddr = 32'h40; awvalid = 1; wdata = 32'hA5A5A5A5; wstrb = 4'hF; wvalid = 1;
        @(negedge clk);
        awvalid = 0; wvalid = 0;
        chk("t4_bresp", bresp, CHK ? 2'b10 : 2'b00);
        chk("t4_reg0", reg_q[31:0], CHK ? 32'h0 : 32'hA5A5A5A5);
        chk("t4_pulse", wr_pulse, CHK ? 1'b0 : 1'b1);
        bready = 1;
        araddr = 32'h40; arvalid = 1;
        @(negedge clk);
        bready = 0; arvalid = 0;
        chk("t4_rresp", rresp, CHK ? 2'b10 : 2'b00);
        chk("t4_rdata", rdata, CHK ? 32'h0 : 32'hA5A5A5A5);
        rready = 1;
        @(negedge clk);
        rready = 0;

        // Read and write of reg2 in the same cycle; ADDR[1:0] ignored
        awaddr = 32'h08; awvalid = 1; wdata = 32'h12345678; wstrb = 4'b1100; wvalid = 1;
        araddr = 32'h0B; arvalid = 1;
        @(negedge clk);
        awvalid = 0; wvalid = 0; arvalid = 0;
        chk("t5_rdata_pre", rdata, 32'hDEADBEEF);
        chk("t5_reg2", reg_q[95:64], 32'h1234BEEF);
        chk("t5_idx", wr_idx, 2);
        bready = 1; rready = 1;
        @(negedge clk);
        bready = 0; rready = 0;

        // Reset while in WR_WAIT_W
        awaddr = 32'h0C; awvalid = 1;
        @(negedge clk);
        awvalid = 0;
        chk("t6_awready", awready, 0);
        chk("t6_wready", wready, 1);
        rst = 1;
        wdata = 32'hFFFFFFFF; wstrb = 4'hF; wvalid = 1;
        @(negedge clk);
        chk("t6_rst_wready", wready, 0);
        rst = 0; wvalid = 0;
        @(negedge clk);
        chk("t6_bvalid", bvalid, 0);
        chk("t6_regq_zero", (reg_q == '0), 1);
        chk("t6_awready", awready, 1);
        @(negedge clk);
        @(negedge clk);
        chk("t6_bvalid_late", bvalid, 0);
        chk("t6_pulse_late", wr_pulse, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
